// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Produces {remainder, quotient} after WIDTH iterations and stalls the pipeline while busy.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 stall_div,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;

    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    // Two's-complement absolute value; the most negative value maps to itself as unsigned.
    always_comb begin
        dvd_mag = (signed_div && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
        dvs_mag = (signed_div && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;
    end

    // quo_reg doubles as the dividend shift register: its MSB feeds the remainder
    // while quotient bits enter at the LSB.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        trial     = rem_shift - {2'b00, dvs_reg};
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b0};
        end
        quo_fix = neg_q_reg ? (WIDTH'(0) - quo_next) : quo_next;
        rem_fix = neg_r_reg ? (WIDTH'(0) - rem_next[WIDTH-1:0]) : rem_next[WIDTH-1:0];
    end

    assign stall_div = (((state_reg == IDLE) && start) || (state_reg == CALC)) && !annul;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            ready     <= 1'b0;
            result    <= '0;
        end else begin
            ready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !annul) begin
                        neg_q_reg <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_reg <= signed_div && dividend[WIDTH-1];
                        quo_reg   <= dvd_mag;
                        dvs_reg   <= dvs_mag;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        if (divisor == '0) begin
                            result    <= {dividend, {WIDTH{1'b1}}};
                            ready     <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (annul) begin
                        state_reg <= IDLE;
                    end else begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CW'(WIDTH - 1)) begin
                            result    <= {rem_fix, quo_fix};
                            ready     <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: expected results are queued at issue and
// popped when ready pulses; latency, stall, annul and reset behaviour are checked.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        stall_div;
    logic        ready;
    logic [63:0] result;

    logic [63:0] exp_q[$];
    logic [63:0] last_exp;
    int          checks = 0;
    int          passes = 0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .dividend   (dividend),
        .divisor    (divisor),
        .stall_div  (stall_div),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        ma = (sd && a[31]) ? 32'd0 - a : a;
        mb = (sd && b[31]) ? 32'd0 - b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sd && (a[31] ^ b[31])) q = 32'd0 - q;
        if (sd && a[31]) r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] e);
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        exp_q.push_back(e);
        #1;
        check({tag, " stall_c0"}, {63'd0, stall_div}, 64'd1);
        $display("issue %s: sd=%0d %h / %h expect %h", tag, sd, a, b, e);
    endtask

    // Waits (bounded) for ready, then checks latency, stalls and the popped result.
    task automatic finish_div(input string tag, input int lat, input bit hold);
        int          n;
        bit          calc_ok;
        logic [63:0] e;
        n       = 0;
        calc_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) begin
                dividend   = $urandom;
                divisor    = $urandom;
                signed_div = ~signed_div;
            end
            if (ready) begin
                n = i;
                break;
            end
            if (!stall_div) calc_ok = 1'b0;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        last_exp = e;
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " stall_calc"}, {63'd0, calc_ok}, 64'd1);
        check({tag, " stall_done"}, {63'd0, stall_div}, 64'd0);
        check({tag, " result"}, result, e);
        $display("done %s: cycles=%0d result=%h", tag, n, result);
        if (!hold) begin
            start = 1'b0;
            tick();
            check({tag, " ready_single"}, {63'd0, ready}, 64'd0);
            check({tag, " result_hold"}, result, e);
        end
    endtask

    initial begin
        int pulses;
        logic [31:0] a, b;
        logic        sd;

        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0; last_exp = '0;
        repeat (2) tick();
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        check("reset stall", {63'd0, stall_div}, 64'd0);
        rst = 1'b1;
        tick();

        issue("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'hE});
        finish_div("divu_100_7", 33, 1'b0);
        issue("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        finish_div("div_m7_2", 33, 1'b0);
        issue("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        finish_div("div_7_m2", 33, 1'b0);
        issue("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        finish_div("div_min_m1", 33, 1'b0);
        issue("divu_zero", 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
        finish_div("divu_zero", 1, 1'b0);
        issue("div_zero", 1'b1, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
        finish_div("div_zero", 1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd3;
            sd = k[0];
            issue("rand", sd, a, b, model(sd, a, b));
            finish_div("rand", 33, 1'b0);
        end

        // Back-to-back: start stays high through DONE into the next acceptance.
        issue("b2b_1", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});
        finish_div("b2b_1", 33, 1'b1);
        signed_div = 1'b1;
        dividend   = 32'hFFFF_FF9C;
        divisor    = 32'd7;
        exp_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
        tick();
        check("b2b idle_stall", {63'd0, stall_div}, 64'd1);
        check("b2b idle_ready", {63'd0, ready}, 64'd0);
        finish_div("b2b_2", 33, 1'b0);

        // Annul on cycle 10 of a divide.
        signed_div = 1'b0; dividend = 32'd500; divisor = 32'd5; start = 1'b1;
        #1;
        check("annul stall_c0", {63'd0, stall_div}, 64'd1);
        repeat (10) tick();
        annul = 1'b1;
        #1;
        check("annul stall_drop", {63'd0, stall_div}, 64'd0);
        tick();
        annul = 1'b0;
        start = 1'b0;
        #1;
        check("annul back_idle", {63'd0, stall_div}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready) pulses++;
        end
        check("annul no_ready", 64'(pulses), 64'd0);
        check("annul result_kept", result, last_exp);
        $display("annul: ready pulses=%0d result=%h", pulses, result);
        issue("after_annul", 1'b0, 32'd500, 32'd5, {32'd0, 32'd100});
        finish_div("after_annul", 33, 1'b0);

        // Asynchronous reset on cycle 15 of a divide.
        signed_div = 1'b0; dividend = 32'hDEAD; divisor = 32'd3; start = 1'b1;
        repeat (15) tick();
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("rst_mid ready", {63'd0, ready}, 64'd0);
        check("rst_mid result", result, 64'd0);
        check("rst_mid stall", {63'd0, stall_div}, 64'd0);
        $display("reset mid-calc: ready=%0d result=%h stall=%0d", ready, result, stall_div);
        tick();
        rst = 1'b1;
        tick();
        issue("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
        finish_div("divu_max_1", 33, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
